// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// The Booth digit encoding is only consumed when MULTDIV_BOOTH_EN is defined.
package multdiv_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMult,
        StDiv,
        StDone
    } state_e;

    typedef enum logic [2:0] {
        BoothZero,
        BoothPos1,
        BoothPos2,
        BoothNeg1,
        BoothNeg2
    } booth_e;

    function automatic logic [127:0] int_min(input int unsigned width);
        return 128'(1) << (width - 1);
    endfunction

    // Triplet is {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_e booth_decode(input logic [2:0] trip);
        booth_e d;
        unique case (trip)
            3'b001, 3'b010: d = BoothPos1;
            3'b011:         d = BoothPos2;
            3'b100:         d = BoothNeg2;
            3'b101, 3'b110: d = BoothNeg1;
            default:        d = BoothZero;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/multdiv_counter.sv
// Synchronous-clear iteration counter; tc_o flags that the count equals term_i.
module multdiv_counter #(
    parameter int unsigned Width = 6
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [Width-1:0] term_i,
    output logic             tc_o
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + Width'(1);
        end
    end

    assign tc_o = (count_q == term_i);

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiplier/divider with a fixed latency per operation.
// MULTDIV_BOOTH_EN selects a radix-4 Booth multiply (WIDTH/2 iterations).
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] IntMin = WIDTH'(int_min(WIDTH));
    localparam logic [CNT_W-1:0] TermFull = CNT_W'(WIDTH - 1);
`ifdef MULTDIV_BOOTH_EN
    localparam int unsigned HiW = WIDTH + 2;
    localparam logic [CNT_W-1:0] TermHalf = CNT_W'(WIDTH / 2 - 1);
`else
    localparam int unsigned HiW = WIDTH;
`endif

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] e;
        e = {v[WIDTH-1], v};
        return v[WIDTH-1] ? WIDTH'(-e) : v;
    endfunction

    state_e           state_q;
    logic [HiW-1:0]   hi_q, it_hi;
    logic [WIDTH-1:0] lo_q, it_lo, opnd_q;
    logic             neg_q, dzero_q, ovf_q;
    logic [WIDTH-1:0] result_q;
    logic             exc_q, rdy_q, busy_q;
    logic             start, iterating, tc;
    logic [CNT_W-1:0] term;

    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_raw, prod;
    logic [WIDTH-1:0]   quo, fin_result;
    logic               mul_exc, fin_exc;

`ifdef MULTDIV_BOOTH_EN
    logic           prev_q, it_prev;
    logic [HiW-1:0] booth_m, booth_add, booth_sum;
`else
    logic [WIDTH:0] mul_sum;
`endif

    assign start     = ctrl_MULT | ctrl_DIV;
    assign iterating = (state_q == StMult) || (state_q == StDiv);

`ifdef MULTDIV_BOOTH_EN
    assign term = (state_q == StMult) ? TermHalf : TermFull;
`else
    assign term = TermFull;
`endif

    multdiv_counter #(
        .Width (CNT_W)
    ) u_counter (
        .clk_i  (clock),
        .clr_i  (reset | start),
        .en_i   (iterating),
        .term_i (term),
        .tc_o   (tc)
    );

    // One iteration of the active operation.
    always_comb begin
        it_hi     = hi_q;
        it_lo     = lo_q;
        div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
`ifdef MULTDIV_BOOTH_EN
        it_prev   = prev_q;
        booth_m   = {{2{opnd_q[WIDTH-1]}}, opnd_q};
        unique case (booth_decode({lo_q[1:0], prev_q}))
            BoothPos1: booth_add = booth_m;
            BoothPos2: booth_add = booth_m << 1;
            BoothNeg1: booth_add = -booth_m;
            BoothNeg2: booth_add = -(booth_m << 1);
            default:   booth_add = '0;
        endcase
        booth_sum = hi_q + booth_add;
`else
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
`endif
        if (state_q == StDiv) begin
            it_hi = div_ge ? HiW'(div_shift - {1'b0, opnd_q}) : HiW'(div_shift[WIDTH-1:0]);
            it_lo = {lo_q[WIDTH-2:0], div_ge};
        end else if (state_q == StMult) begin
`ifdef MULTDIV_BOOTH_EN
            it_hi   = {{2{booth_sum[WIDTH+1]}}, booth_sum[WIDTH+1:2]};
            it_lo   = {booth_sum[1:0], lo_q[WIDTH-1:2]};
            it_prev = lo_q[1];
`else
            it_hi = mul_sum[WIDTH:1];
            it_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
`endif
        end
    end

    // Final result formed from the last iteration so it registers on the edge entering DONE.
    always_comb begin
        prod_raw = {it_hi[WIDTH-1:0], it_lo};
`ifdef MULTDIV_BOOTH_EN
        prod = prod_raw;
`else
        prod = neg_q ? -prod_raw : prod_raw;
`endif
        mul_exc = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
        quo     = neg_q ? -it_lo : it_lo;
        if (state_q == StMult) begin
            fin_result = prod[WIDTH-1:0];
            fin_exc    = mul_exc;
        end else if (dzero_q) begin
            fin_result = '0;
            fin_exc    = 1'b1;
        end else if (ovf_q) begin
            fin_result = IntMin;
            fin_exc    = 1'b1;
        end else begin
            fin_result = quo;
            fin_exc    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            dzero_q  <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef MULTDIV_BOOTH_EN
            prev_q   <= 1'b0;
`endif
        end else begin
            rdy_q <= 1'b0;
            if (start) begin
                // A start in any state restarts; MULT wins over DIV.
                state_q <= ctrl_MULT ? StMult : StDiv;
                busy_q  <= 1'b1;
                hi_q    <= '0;
                neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                dzero_q <= (data_operandB == '0);
                ovf_q   <= (data_operandA == IntMin) && (data_operandB == '1);
                if (ctrl_MULT) begin
`ifdef MULTDIV_BOOTH_EN
                    opnd_q <= data_operandA;
                    lo_q   <= data_operandB;
                    prev_q <= 1'b0;
`else
                    opnd_q <= mag(data_operandA);
                    lo_q   <= mag(data_operandB);
`endif
                end else begin
                    opnd_q <= mag(data_operandB);
                    lo_q   <= mag(data_operandA);
                end
            end else begin
                unique case (state_q)
                    StMult, StDiv: begin
                        hi_q <= it_hi;
                        lo_q <= it_lo;
`ifdef MULTDIV_BOOTH_EN
                        prev_q <= it_prev;
`endif
                        if (tc) begin
                            state_q  <= StDone;
                            busy_q   <= 1'b0;
                            rdy_q    <= 1'b1;
                            result_q <= fin_result;
                            exc_q    <= fin_exc;
                        end
                    end
                    StDone:  state_q <= StIdle;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed self-checking bench for multdiv_unit (honours MULTDIV_BOOTH_EN for MULT latency).
module tb_multdiv_unit;

`ifdef MULTDIV_BOOTH_EN
    localparam int MulLat = 16;
`else
    localparam int MulLat = 32;
`endif
    localparam int DivLat = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_operandA, data_operandB;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;

    int checks = 0;
    int passes = 0;

    multdiv_unit #(
        .WIDTH (32)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // One-cycle start pulse; operands scrambled afterwards since they must only be sampled at start.
    task automatic start_op(input logic mul, input logic div, input logic [31:0] a,
                            input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT = mul;
        ctrl_DIV = div;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Edges after the start edge until data_resultRDY is seen (bounded).
    task automatic wait_rdy(output int n);
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!data_resultRDY && n < 100);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if (data_result !== 32'h0) $display("FAIL reset_result: got %h expected 0", data_result);
        else passes++;
        checks++;
        if (data_exception !== 1'b0) $display("FAIL reset_exc: got %b expected 0", data_exception);
        else passes++;
        checks++;
        if (data_resultRDY !== 1'b0) $display("FAIL reset_rdy: got %b expected 0", data_resultRDY);
        else passes++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
        else passes++;
        reset = 1'b0;
    endtask

    task automatic test_mult_basic();
        int n;
        start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA);
        checks++;
        if (busy !== 1'b1) $display("FAIL mult_busy: got %b expected 1", busy);
        else passes++;
        wait_rdy(n);
        checks++;
        if (n != MulLat) $display("FAIL mult_latency: got %0d expected %0d", n, MulLat);
        else passes++;
        checks++;
        if (data_result !== 32'hFFFF_FFD6)
            $display("FAIL mult_7x-6: got %h expected ffffffd6", data_result);
        else passes++;
        checks++;
        if (data_exception !== 1'b0) $display("FAIL mult_7x-6_exc: got %b expected 0", data_exception);
        else passes++;
        checks++;
        if (busy !== 1'b0) $display("FAIL mult_busy_done: got %b expected 0", busy);
        else passes++;
        @(posedge clock);
        #1;
        checks++;
        if (data_resultRDY !== 1'b0 || data_result !== 32'hFFFF_FFD6)
            $display("FAIL mult_pulse_hold: got rdy=%b res=%h expected rdy=0 res=ffffffd6",
                     data_resultRDY, data_result);
        else passes++;
    endtask

    task automatic test_mult_overflow();
        int n;
        start_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        wait_rdy(n);
        checks++;
        if (data_result !== 32'h0 || data_exception !== 1'b1)
            $display("FAIL mult_ovf: got res=%h exc=%b expected res=0 exc=1", data_result,
                     data_exception);
        else passes++;
        start_op(1'b1, 1'b0, 32'h8000_0000, 32'h1);
        wait_rdy(n);
        checks++;
        if (data_result !== 32'h8000_0000 || data_exception !== 1'b0)
            $display("FAIL mult_intmin_x1: got res=%h exc=%b expected res=80000000 exc=0",
                     data_result, data_exception);
        else passes++;
        start_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_rdy(n);
        checks++;
        if (data_result !== 32'h1 || data_exception !== 1'b0)
            $display("FAIL mult_neg1_sq: got res=%h exc=%b expected res=1 exc=0", data_result,
                     data_exception);
        else passes++;
    endtask

    task automatic test_div();
        int n;
        start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_rdy(n);
        checks++;
        if (n != DivLat) $display("FAIL div_latency: got %0d expected %0d", n, DivLat);
        else passes++;
        checks++;
        if (data_result !== 32'hFFFF_FFFD || data_exception !== 1'b0)
            $display("FAIL div_-7/2: got res=%h exc=%b expected res=fffffffd exc=0", data_result,
                     data_exception);
        else passes++;
        start_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
        wait_rdy(n);
        checks++;
        if (data_result !== 32'd14 || data_exception !== 1'b0)
            $display("FAIL div_-100/-7: got res=%h exc=%b expected res=e exc=0", data_result,
                     data_exception);
        else passes++;
    endtask

    task automatic test_div_special();
        int n;
        start_op(1'b0, 1'b1, 32'd5, 32'd0);
        wait_rdy(n);
        checks++;
        if (n != DivLat) $display("FAIL div0_latency: got %0d expected %0d", n, DivLat);
        else passes++;
        checks++;
        if (data_result !== 32'h0 || data_exception !== 1'b1)
            $display("FAIL div_by_zero: got res=%h exc=%b expected res=0 exc=1", data_result,
                     data_exception);
        else passes++;
        start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_rdy(n);
        checks++;
        if (data_result !== 32'h8000_0000 || data_exception !== 1'b1)
            $display("FAIL div_intmin_neg1: got res=%h exc=%b expected res=80000000 exc=1",
                     data_result, data_exception);
        else passes++;
    endtask

    task automatic test_priority();
        int n;
        start_op(1'b1, 1'b1, 32'd9, 32'd3);
        wait_rdy(n);
        checks++;
        if (n != MulLat) $display("FAIL prio_latency: got %0d expected %0d", n, MulLat);
        else passes++;
        checks++;
        if (data_result !== 32'd27 || data_exception !== 1'b0)
            $display("FAIL prio_mult: got res=%h exc=%b expected res=1b exc=0", data_result,
                     data_exception);
        else passes++;
    endtask

    task automatic test_abort();
        int n;
        int early;
        int late;
        early = 0;
        late = 0;
        start_op(1'b1, 1'b0, 32'd3, 32'd4);
        repeat (8) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) early++;
        end
        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        wait_rdy(n);
        checks++;
        if (early != 0) $display("FAIL abort_early_rdy: got %0d pulses expected 0", early);
        else passes++;
        checks++;
        if (n != DivLat) $display("FAIL abort_latency: got %0d expected %0d", n, DivLat);
        else passes++;
        checks++;
        if (data_result !== 32'd14 || data_exception !== 1'b0)
            $display("FAIL abort_div: got res=%h exc=%b expected res=e exc=0", data_result,
                     data_exception);
        else passes++;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) late++;
        end
        checks++;
        if (late != 0) $display("FAIL abort_extra_rdy: got %0d pulses expected 0", late);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        start_op(1'b1, 1'b0, 32'd123, 32'd456);
        repeat (19) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (data_result !== 32'h0 || data_exception !== 1'b0)
            $display("FAIL rst_mid_outputs: got res=%h exc=%b expected res=0 exc=0", data_result,
                     data_exception);
        else passes++;
        checks++;
        if (busy !== 1'b0 || data_resultRDY !== 1'b0)
            $display("FAIL rst_mid_ctrl: got busy=%b rdy=%b expected 0 0", busy, data_resultRDY);
        else passes++;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        checks++;
        if (pulses != 0) $display("FAIL rst_mid_no_rdy: got %0d pulses expected 0", pulses);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_mult_basic();
        test_mult_overflow();
        test_div();
        test_div_special();
        test_priority();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
